// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer around an external single-step shifter: loads a request,
// steps the shifter once per cycle for req_amt cycles, then holds the result on a valid/ready response.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [WIDTH-1:0] req_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [1:0]       sh_shift,
  output logic [WIDTH-1:0] sh_in,
  input  logic [WIDTH-1:0] sh_out
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= 2'b00;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc  <= req_data;
            op_r <= req_op;
            cnt  <= req_amt;
          end
        end
        SHIFT: begin
          // SHIFT is only entered with cnt >= 1 and left when cnt reaches 1, so no underflow.
          acc <= sh_out;
          cnt <= cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_amt == '0 || req_op == 2'b00) state_nx = DONE;
          else                                  state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) state_nx = DONE;
      end
      DONE: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state == SHIFT) || (state == DONE);
  assign sh_shift   = (state == SHIFT) ? op_r : 2'b00;
  assign sh_in      = acc;
  assign resp_data  = acc;

endmodule
